// File: rtl/reorder_buffer.sv
// In-order retirement buffer fed by the CDB; allocates at tail, retires at head.
// Ports: clk/reset, alloc_* issue side, cdb_* broadcast side, commit_* retire side, count/empty.
module reorder_buffer #(
  parameter int DEPTH  = 8,
  parameter int TAG_W  = 4,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     alloc_valid,
  input  logic [4:0]               alloc_rd,
  input  logic [TAG_W-1:0]         alloc_tag,
  output logic                     alloc_ready,
  input  logic                     cdb_valid,
  input  logic [TAG_W-1:0]         cdb_tag,
  input  logic [DATA_W-1:0]        cdb_data,
  output logic                     commit_valid,
  output logic [4:0]               commit_rd,
  output logic [TAG_W-1:0]         commit_tag,
  output logic [DATA_W-1:0]        commit_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic              r_valid [DEPTH];
  logic              r_done  [DEPTH];
  logic [4:0]        r_rd    [DEPTH];
  logic [TAG_W-1:0]  r_tag   [DEPTH];
  logic [DATA_W-1:0] r_data  [DEPTH];
  logic [PW-1:0]     r_head;
  logic [PW-1:0]     r_tail;
  logic [CW-1:0]     r_count;

  logic              r_cv;
  logic [4:0]        r_crd;
  logic [TAG_W-1:0]  r_ctag;
  logic [DATA_W-1:0] r_cdata;

  logic              w_alloc_fire;
  logic              w_commit_fire;
  logic              w_hit;
  logic [PW-1:0]     w_idx;
  logic              w_cap;

  assign alloc_ready   = (r_count != CW'(DEPTH));
  assign empty         = (r_count == '0);
  assign count         = r_count;
  assign w_alloc_fire  = alloc_valid && alloc_ready;
  assign w_commit_fire = r_valid[r_head] && r_done[r_head];

  // Oldest pending entry with a matching tag, walking from head.
  always_comb begin
    logic [PW-1:0] pos;
    w_hit = 1'b0;
    w_idx = '0;
    pos   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      pos = r_head + PW'(i);
      if (!w_hit && r_valid[pos] && !r_done[pos]
          && r_tag[pos] == cdb_tag) begin
        w_hit = 1'b1;
        w_idx = pos;
      end
    end
  end

  assign w_cap = cdb_valid && (cdb_tag != '0) && w_hit;

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_valid[i] <= 1'b0;
        r_done[i]  <= 1'b0;
      end
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_cv    <= 1'b0;
      r_crd   <= '0;
      r_ctag  <= '0;
      r_cdata <= '0;
    end else begin
      if (w_cap) begin
        r_done[w_idx] <= 1'b1;
        r_data[w_idx] <= cdb_data;
      end
      r_cv <= w_commit_fire;
      if (w_commit_fire) begin
        r_valid[r_head] <= 1'b0;
        r_done[r_head]  <= 1'b0;
        r_crd           <= r_rd[r_head];
        r_ctag          <= r_tag[r_head];
        r_cdata         <= r_data[r_head];
        r_head          <= r_head + 1'b1;
      end
      // Tail slot is never the capture target: it is invalid before this edge.
      if (w_alloc_fire) begin
        r_valid[r_tail] <= 1'b1;
        r_done[r_tail]  <= (alloc_tag == '0);
        r_rd[r_tail]    <= alloc_rd;
        r_tag[r_tail]   <= alloc_tag;
        r_data[r_tail]  <= '0;
        r_tail          <= r_tail + 1'b1;
      end
      r_count <= r_count + CW'(w_alloc_fire) - CW'(w_commit_fire);
    end
  end

  assign commit_valid = r_cv;
  assign commit_rd    = r_crd;
  assign commit_tag   = r_ctag;
  assign commit_data  = r_cdata;
endmodule

// File: tb/tb_reorder_buffer.sv
// Randomized and directed bench for reorder_buffer against a queue model.
// Drives inputs #1 after each rising edge and checks every cycle.
module tb_reorder_buffer;
  localparam int DEPTH = 8;

  logic        clk = 0;
  logic        reset;
  logic        alloc_valid;
  logic [4:0]  alloc_rd;
  logic [3:0]  alloc_tag;
  logic        alloc_ready;
  logic        cdb_valid;
  logic [3:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic        commit_valid;
  logic [4:0]  commit_rd;
  logic [3:0]  commit_tag;
  logic [31:0] commit_data;
  logic [3:0]  count;
  logic        empty;

  reorder_buffer dut (
    .clk(clk), .reset(reset),
    .alloc_valid(alloc_valid), .alloc_rd(alloc_rd),
    .alloc_tag(alloc_tag), .alloc_ready(alloc_ready),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .commit_valid(commit_valid), .commit_rd(commit_rd),
    .commit_tag(commit_tag), .commit_data(commit_data),
    .count(count), .empty(empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [3:0]  tag;
    logic        done;
    logic [31:0] data;
  } ent_t;

  ent_t        q[$];
  logic        m_cv;
  logic [4:0]  m_crd;
  logic [3:0]  m_ctag;
  logic [31:0] m_cdata;

  int passed = 0;
  int total  = 0;
  int pulses = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic model(input logic rv, input logic av,
                       input logic [4:0] rd, input logic [3:0] tg,
                       input logic cv, input logic [3:0] ct,
                       input logic [31:0] cd);
    logic cf, af;
    if (!rv) begin
      q.delete();
      m_cv = 0; m_crd = 0; m_ctag = 0; m_cdata = 0;
      return;
    end
    cf = (q.size() > 0) && q[0].done;
    af = av && (q.size() < DEPTH);
    if (cv && ct != 0) begin
      for (int i = 0; i < q.size(); i++) begin
        if (!q[i].done && q[i].tag == ct) begin
          q[i].done = 1;
          q[i].data = cd;
          break;
        end
      end
    end
    m_cv = cf;
    if (cf) begin
      m_crd = q[0].rd; m_ctag = q[0].tag; m_cdata = q[0].data;
      void'(q.pop_front());
    end
    if (af) q.push_back('{rd, tg, tg == 0, 32'h0});
  endtask

  task automatic cyc(input logic rv, input logic av,
                     input logic [4:0] rd, input logic [3:0] tg,
                     input logic cv, input logic [3:0] ct,
                     input logic [31:0] cd);
    reset = rv; alloc_valid = av; alloc_rd = rd; alloc_tag = tg;
    cdb_valid = cv; cdb_tag = ct; cdb_data = cd;
    model(rv, av, rd, tg, cv, ct, cd);
    @(posedge clk);
    #1;
    if (commit_valid === 1'b1) pulses++;
    chk("commit_valid", commit_valid, m_cv);
    chk("commit_rd",    commit_rd,    m_crd);
    chk("commit_tag",   commit_tag,   m_ctag);
    chk("commit_data",  commit_data,  m_cdata);
    chk("count",        count,        q.size());
    chk("empty",        empty,        q.size() == 0);
    chk("alloc_ready",  alloc_ready,  q.size() != DEPTH);
  endtask

  task automatic idle();
    cyc(1, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic al(input logic [4:0] rd, input logic [3:0] tg);
    cyc(1, 1, rd, tg, 0, 0, 0);
  endtask

  task automatic bc(input logic [3:0] ct, input logic [31:0] cd);
    cyc(1, 0, 0, 0, 1, ct, cd);
  endtask

  initial begin
    reset = 0; alloc_valid = 0; alloc_rd = 0; alloc_tag = 0;
    cdb_valid = 0; cdb_tag = 0; cdb_data = 0;
    m_cv = 0; m_crd = 0; m_ctag = 0; m_cdata = 0;

    // reset
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    idle();
    chk("pin_rst_count", count, 0);
    chk("pin_rst_empty", empty, 1);
    chk("pin_rst_ready", alloc_ready, 1);
    chk("pin_rst_cv", commit_valid, 0);

    // in-order retire
    al(3, 1);
    al(5, 2);
    bc(2, 32'hBB);
    chk("pin_ooo_nocommit", commit_valid, 0);
    bc(1, 32'hAA);
    idle();
    chk("pin_c1_valid", commit_valid, 1);
    chk("pin_c1_rd", commit_rd, 3);
    chk("pin_c1_data", commit_data, 32'hAA);
    idle();
    chk("pin_c2_valid", commit_valid, 1);
    chk("pin_c2_rd", commit_rd, 5);
    chk("pin_c2_data", commit_data, 32'hBB);
    idle();
    chk("pin_hold_data", commit_data, 32'hBB);

    // full and wrap
    for (int i = 1; i <= 8; i++) al(5'(i), 4'(i));
    chk("pin_full_ready", alloc_ready, 0);
    chk("pin_full_count", count, 8);
    al(9, 9);
    chk("pin_9th_count", count, 8);
    pulses = 0;
    for (int i = 1; i <= 8; i++) bc(4'(i), 32'(i * 16));
    for (int i = 0; i < 4; i++) idle();
    for (int i = 1; i <= 8; i++) al(5'(i + 10), 4'(i));
    for (int i = 1; i <= 8; i++) bc(4'(i), 32'(i + 256));
    for (int i = 0; i < 12; i++) idle();
    chk("pin_wrap_pulses", pulses, 16);
    chk("pin_wrap_last", commit_rd, 18);
    chk("pin_wrap_empty", empty, 1);

    // duplicate tag
    al(1, 4);
    al(2, 4);
    bc(4, 32'h11);
    idle();
    chk("pin_dup1_cv", commit_valid, 1);
    chk("pin_dup1_rd", commit_rd, 1);
    chk("pin_dup1_data", commit_data, 32'h11);
    bc(4, 32'h22);
    chk("pin_dup_gap", commit_valid, 0);
    idle();
    chk("pin_dup2_rd", commit_rd, 2);
    chk("pin_dup2_data", commit_data, 32'h22);

    // same-edge alloc + broadcast, then tag 0 broadcast
    cyc(1, 1, 7, 6, 1, 6, 32'h66);
    idle();
    idle();
    chk("pin_same_cv", commit_valid, 0);
    chk("pin_same_count", count, 1);
    bc(0, 32'h99);
    idle();
    chk("pin_tag0_cv", commit_valid, 0);
    bc(6, 32'h77);
    idle();
    chk("pin_late_cv", commit_valid, 1);
    chk("pin_late_data", commit_data, 32'h77);

    // reset with done entries blocked behind a pending head
    al(1, 9);
    al(2, 10);
    al(3, 11);
    al(4, 12);
    bc(10, 1);
    bc(11, 2);
    bc(12, 3);
    chk("pin_pend_count", count, 4);
    pulses = 0;
    cyc(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) idle();
    chk("pin_rst2_pulses", pulses, 0);
    chk("pin_rst2_count", count, 0);
    chk("pin_rst2_data", commit_data, 0);

    // random
    for (int n = 0; n < 2000; n++) begin
      logic rv, av, cv;
      logic [3:0] ct;
      rv = ($urandom_range(0, 299) != 0);
      av = ($urandom_range(0, 99) < 55);
      cv = ($urandom_range(0, 99) < 60);
      ct = 4'($urandom_range(0, 7));
      if (cv && q.size() > 0 && $urandom_range(0, 1) == 1)
        ct = q[$urandom_range(0, q.size() - 1)].tag;
      cyc(rv, av, 5'($urandom), 4'($urandom_range(0, 7)),
          cv, ct, $urandom);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
